fir_t_dec: RTL and testbench

FIR_T_DEC -- requirements
Module: fir_t_dec

---
 rtl/fse_pkg.sv | 33 +++
 rtl/fir_t_sat.sv | 43 ++++
 rtl/fir_t_dec.sv | 148 ++++++++++++++
 tb/tb_fir_t_dec.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fse_pkg.sv
// fse_pkg: derived-width helpers shared by fir_t_dec and fir_t_sat.
package fse_pkg;

    // Width of the clip counter
    localparam int CNT_W = 16;

    // Full-precision product width of one sample times one tap
    function automatic int prod_w(input int nbin, input int nbcoeff);
        return nbin + nbcoeff;
    endfunction

    // Guard bits so a sum of ncoeff products can never overflow
    function automatic int guard_w(input int ncoeff);
        return (ncoeff > 1) ? $clog2(ncoeff) : 0;
    endfunction

    // Accumulator width of the sum chain
    function automatic int acc_w(input int nbin, input int nbcoeff, input int ncoeff);
        return prod_w(nbin, nbcoeff) + guard_w(ncoeff);
    endfunction

    // Bits at and above the output sign position of the (sign-extended)
    // quantised value; all must match for the result to fit unclipped
    function automatic int sat_w(input int nbi, input int nbo);
        return nbi + 2 - nbo;
    endfunction

    // Phase select width, at least one bit
    function automatic int phase_w(input int dec);
        return (dec > 1) ? $clog2(dec) : 1;
    endfunction

endpackage

// File: rtl/fir_t_sat.sv
// fir_t_sat: quantise a wide fixed-point value to NBO/NBFO and saturate.
// Truncates (floor) by default; FIR_T_DEC_ROUND_EN selects round half-up.
module fir_t_sat
    import fse_pkg::*;
#(
    parameter int NBI  = 19,
    parameter int NBFI = 10,
    parameter int NBO  = 8,
    parameter int NBFO = 5
) (
    input  logic [NBI-1:0] in_i,
    output logic [NBO-1:0] y_o,
    output logic           sat_o
);

    localparam int SH   = NBFI - NBFO;
    localparam int XW   = NBI + 1;
    localparam int TOPW = sat_w(NBI, NBO);

    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] rnd;
    logic signed [XW-1:0] q;
    logic [TOPW-1:0]      top;

    // One extra sign bit so the rounding add can never wrap
    assign ext = $signed({in_i[NBI-1], in_i});

`ifdef FIR_T_DEC_ROUND_EN
    localparam int           HSH  = (SH > 0) ? SH - 1 : 0;
    localparam logic [XW-1:0] HALF = (SH > 0) ? (XW'(1) << HSH) : '0;
    assign rnd = ext + $signed(HALF);
`else
    assign rnd = ext;
`endif

    assign q   = rnd >>> SH;
    assign top = q[XW-1:NBO-1];

    // Clip whenever the bits above the output sign disagree with it
    assign sat_o = !((top == '0) || (top == '1));
    assign y_o   = sat_o ? {q[XW-1], {(NBO-1){~q[XW-1]}}} : q[NBO-1:0];

endmodule

// File: rtl/fir_t_dec.sv
// fir_t_dec: transposed-form FIR with decimating output phase select,
// shadowed coefficient loads and a saturating clip counter.
// Three-stage pipeline: input register, sum chain, output register.
// Build option FIR_T_DEC_ROUND_EN: round half-up instead of truncate.
module fir_t_dec
    import fse_pkg::*;
#(
    parameter int NBin     = 8,
    parameter int NBFin    = 5,
    parameter int NBout    = 8,
    parameter int NBFout   = 5,
    parameter int Ncoeff   = 9,
    parameter int NBcoeff  = 7,
    parameter int NBFcoeff = 5,
    parameter int DEC      = 2,
    localparam int PW      = phase_w(DEC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_valid,
    input  logic [NBin-1:0]           i_x,
    input  logic [Ncoeff*NBcoeff-1:0] i_coeff,
    input  logic                      i_coeff_load,
    input  logic [PW-1:0]             i_phase,
    input  logic                      i_sat_clr,
    output logic                      o_valid,
    output logic [NBout-1:0]          o_y,
    output logic                      o_sat,
    output logic [CNT_W-1:0]          o_sat_cnt
);

    localparam int PRODW = prod_w(NBin, NBcoeff);
    localparam int ACCW  = acc_w(NBin, NBcoeff, Ncoeff);
    localparam int GW    = ACCW - PRODW;
    localparam int TW    = Ncoeff * NBcoeff;

    logic [NBin-1:0]              x_q;
    logic [1:0]                   vld_pipe_q;
    logic [1:0]                   sel_pipe_q;
    logic [TW-1:0]                taps_q, taps_d, shadow_q;
    logic                         pending_q;
    logic [PW-1:0]                phase_q, phase_d;
    logic                         hit;
    logic [Ncoeff-1:0][PRODW-1:0] prod;
    logic [Ncoeff-1:0][ACCW-1:0]  pext, sum_q, sum_d;
    logic [NBout-1:0]             y_sat, o_y_q;
    logic                         clip, fire, o_valid_q, o_sat_q;
    logic [CNT_W-1:0]             cnt_q;

    // A load coincident with a sample wins over the shadow bank
    assign taps_d  = i_coeff_load ? i_coeff : (pending_q ? shadow_q : taps_q);
    assign phase_d = (phase_q == PW'(DEC - 1)) ? '0 : phase_q + PW'(1);
    assign hit     = (DEC == 1) || (phase_q == i_phase);
    assign fire    = vld_pipe_q[1] & sel_pipe_q[1];

    for (genvar k = 0; k < Ncoeff; k++) begin : g_tap
        logic [NBcoeff-1:0] w;
        assign w       = taps_q[NBcoeff*(k+1)-1 -: NBcoeff];
        // Both operands sign-extended to the product width
        assign prod[k] = {{NBcoeff{x_q[NBin-1]}}, x_q} * {{NBin{w[NBcoeff-1]}}, w};
        if (GW > 0) begin : g_ext
            assign pext[k] = {{GW{prod[k][PRODW-1]}}, prod[k]};
        end else begin : g_noext
            assign pext[k] = prod[k];
        end
        if (k < Ncoeff - 1) begin : g_mid
            assign sum_d[k] = pext[k] + sum_q[k+1];
        end else begin : g_last
            assign sum_d[k] = pext[k];
        end
    end

    fir_t_sat #(
        .NBI  (ACCW),
        .NBFI (NBFin + NBFcoeff),
        .NBO  (NBout),
        .NBFO (NBFout)
    ) u_sat (
        .in_i  (sum_q[0]),
        .y_o   (y_sat),
        .sat_o (clip)
    );

    // Valid and phase-match shift register tracking stages 1 and 2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            sel_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], i_valid};
            sel_pipe_q <= {sel_pipe_q[0], hit};
        end
    end

    // Stage 1: capture accepted sample, commit taps, advance phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            taps_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            phase_q   <= '0;
        end else begin
            if (i_coeff_load) shadow_q <= i_coeff;
            if (i_valid) begin
                x_q       <= i_x;
                taps_q    <= taps_d;
                pending_q <= 1'b0;
                phase_q   <= phase_d;
            end else if (i_coeff_load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Stage 2: advance the transposed sum chain on each stage-1 sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (vld_pipe_q[0]) begin
            sum_q <= sum_d;
        end
    end

    // Stage 3: register selected outputs and count clipped ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid_q <= 1'b0;
            o_y_q     <= '0;
            o_sat_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            o_valid_q <= fire;
            if (fire) begin
                o_y_q   <= y_sat;
                o_sat_q <= clip;
            end
            if (i_sat_clr)                          cnt_q <= '0;
            else if (fire && clip && cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_valid   = o_valid_q;
    assign o_y       = o_y_q;
    assign o_sat     = o_sat_q;
    assign o_sat_cnt = cnt_q;

endmodule

// File: tb/tb_fir_t_dec.sv
// tb_fir_t_dec: four fir_t_dec instances (DEC 1/2/3 with 3 taps, and a
// 1-tap NBFout=4 build) share one stimulus stream; a spec-level model
// predicts each output and a monitor checks them against a scoreboard.
module tb_fir_t_dec;

    localparam int NI   = 4;
    localparam int NTAP = 3;
    localparam int CW   = NTAP * 7;

    localparam logic [CW-1:0] TAPS_A = {7'h08, 7'h10, 7'h20};
    localparam logic [CW-1:0] TAPS_B = {7'h70, 7'h20, 7'h18};
    localparam logic [CW-1:0] TAPS_S = {7'h20, 7'h20, 7'h20};

    function automatic int dec_of(input int g);
        return (g == 1) ? 2 : (g == 2) ? 3 : 1;
    endfunction
    function automatic int nc_of(input int g);
        return (g == 3) ? 1 : 3;
    endfunction
    function automatic int nbfo_of(input int g);
        return (g == 3) ? 4 : 5;
    endfunction
    function automatic int pw_of(input int g);
        return (dec_of(g) > 1) ? $clog2(dec_of(g)) : 1;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic i_valid, i_coeff_load, i_sat_clr;
    logic [7:0]    i_x;
    logic [CW-1:0] i_coeff;
    logic [1:0]    i_phase [NI];
    logic          o_valid [NI];
    logic [7:0]    o_y     [NI];
    logic          o_sat   [NI];
    logic [15:0]   o_cnt   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NC  = nc_of(g);
        localparam int PWG = pw_of(g);
        fir_t_dec #(
            .NBout  (8),
            .NBFout (nbfo_of(g)),
            .Ncoeff (NC),
            .DEC    (dec_of(g))
        ) u_dut (
            .clk          (clk),
            .reset        (rst_n),
            .i_valid      (i_valid),
            .i_x          (i_x),
            .i_coeff      (i_coeff[NC*7-1:0]),
            .i_coeff_load (i_coeff_load),
            .i_phase      (i_phase[g][PWG-1:0]),
            .i_sat_clr    (i_sat_clr),
            .o_valid      (o_valid[g]),
            .o_y          (o_y[g]),
            .o_sat        (o_sat[g]),
            .o_sat_cnt    (o_cnt[g])
        );
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic [7:0]    x;
        logic [CW-1:0] w;
    } samp_t;

    typedef struct packed {
        logic [7:0]  y;
        logic        sat;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    samp_t         hist[$];          // newest accepted sample first
    logic [CW-1:0] act_m, shd_m;
    bit            pend_m;
    int            ph_m  [NI];
    int            cnt_m [NI];
    exp_t          expq  [NI][$];
    logic [7:0]    last_y[NI];
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, g, act, exp, $time);
    endfunction

    function automatic int tap_of(input logic [CW-1:0] w, input int k);
        logic [6:0] t;
        t = w[7*k +: 7];
        return int'($signed(t));
    endfunction

    // Fixed-point quantise (floor or round half-up) then clamp to 8 bits
    function automatic void quant(input int acc, input int nf, output int y, output bit sat);
        int sh;
        int a;
        sh = 10 - nf;
        a  = acc;
`ifdef FIR_T_DEC_ROUND_EN
        a  = a + (1 << (sh - 1));
`endif
        y   = a >>> sh;
        sat = 1'b0;
        if (y > 127)  begin y = 127;  sat = 1'b1; end
        if (y < -128) begin y = -128; sat = 1'b1; end
    endfunction

    function automatic void model_reset();
        hist.delete();
        act_m  = '0;
        shd_m  = '0;
        pend_m = 1'b0;
        for (int g = 0; g < NI; g++) begin
            ph_m[g]  = 0;
            cnt_m[g] = 0;
            expq[g].delete();
        end
    endfunction

    function automatic void model_issue(input bit v, input logic [7:0] x, input bit ld,
                                        input logic [CW-1:0] c, input bit clr);
        logic [CW-1:0] used;
        samp_t         s;
        if (clr) for (int g = 0; g < NI; g++) cnt_m[g] = 0;
        if (v) begin
            used   = ld ? c : (pend_m ? shd_m : act_m);
            act_m  = used;
            pend_m = 1'b0;
            if (ld) shd_m = c;
            s.x = x;
            s.w = used;
            hist.push_front(s);
            if (hist.size() > NTAP) void'(hist.pop_back());
            for (int g = 0; g < NI; g++) begin
                int   acc;
                int   y;
                int   pv;
                bit   sat;
                bit   hitm;
                exp_t e;
                // y[n] = sum_k w_k (as loaded for sample n-k) * x[n-k]
                acc = 0;
                for (int k = 0; k < nc_of(g); k++)
                    if (k < hist.size())
                        acc += tap_of(hist[k].w, k) * int'($signed(hist[k].x));
                pv      = int'(i_phase[g]) & ((1 << pw_of(g)) - 1);
                hitm    = (dec_of(g) == 1) || (ph_m[g] == pv);
                ph_m[g] = (ph_m[g] + 1) % dec_of(g);
                if (hitm) begin
                    quant(acc, nbfo_of(g), y, sat);
                    if (sat && cnt_m[g] < 65535) cnt_m[g]++;
                    e.y   = 8'(y);
                    e.sat = sat;
                    e.cnt = 16'(cnt_m[g]);
                    e.cyc = cyc + 3;
                    expq[g].push_back(e);
                end
            end
        end else if (ld) begin
            shd_m  = c;
            pend_m = 1'b1;
        end
    endfunction

    // Monitor: pop and compare on every o_valid; check o_y holds otherwise
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                last_y[g] = 8'h00;
            end else if (o_valid[g]) begin
                if (expq[g].size() == 0) begin
                    chk("unexpected_valid", g, 1, 0);
                end else begin
                    exp_t e;
                    e = expq[g].pop_front();
                    chk("o_y",       g, o_y[g],   e.y);
                    chk("o_sat",     g, o_sat[g], e.sat);
                    chk("o_sat_cnt", g, o_cnt[g], e.cnt);
                    chk("latency",   g, cyc,      e.cyc);
                end
                last_y[g] = o_y[g];
            end else begin
                chk("hold_y", g, o_y[g], last_y[g]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [7:0] x, input bit ld,
                        input logic [CW-1:0] c, input bit clr);
        i_valid      = v;
        i_x          = x;
        i_coeff_load = ld;
        i_coeff      = c;
        i_sat_clr    = clr;
        model_issue(v, x, ld, c, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom), 1'b0, CW'($urandom), 1'b0);
    endtask

    task automatic zeros(input int n);
        repeat (n) step(1'b1, 8'h00, 1'b0, CW'($urandom), 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_x          = '0;
        i_coeff_load = 1'b0;
        i_coeff      = '0;
        i_sat_clr    = 1'b0;
        for (int g = 0; g < NI; g++) i_phase[g] = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_valid", g, o_valid[g], 0);
            chk("rst_y",     g, o_y[g],     0);
            chk("rst_cnt",   g, o_cnt[g],   0);
        end
        rst_n = 1'b1;

        // Impulse after a load with no sample, then two idle cycles
        i_phase[1] = 2'd1;
        step(1'b0, 8'h00, 1'b1, TAPS_A, 1'b0);
        idle(2);
        step(1'b1, 8'h20, 1'b0, '0, 1'b0);
        zeros(5);
        idle(4);

        // Load coincident with the impulse, other taps then back again
        step(1'b1, 8'h20, 1'b1, TAPS_B, 1'b0);
        zeros(4);
        step(1'b1, 8'h20, 1'b1, TAPS_A, 1'b0);
        zeros(4);
        idle(4);

        // Second load overwrites the shadow before commit
        step(1'b0, 8'h00, 1'b1, TAPS_B, 1'b0);
        step(1'b0, 8'h00, 1'b1, TAPS_A, 1'b0);
        step(1'b1, 8'h40, 1'b0, '0, 1'b0);
        zeros(3);

        // Phase selection: DEC=2 odd samples; DEC=3 phase 3 never fires
        i_phase[1] = 2'd1;
        i_phase[2] = 2'd3;
        repeat (8) step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
        idle(4);

        // Saturation both directions, then counter clear
        i_phase[2] = 2'd0;
        step(1'b1, 8'h7F, 1'b1, TAPS_S, 1'b0);
        repeat (5) step(1'b1, 8'h7F, 1'b0, '0, 1'b0);
        repeat (6) step(1'b1, 8'h80, 1'b0, '0, 1'b0);
        idle(5);
        step(1'b0, 8'h00, 1'b0, '0, 1'b1);
        for (int g = 0; g < NI; g++) chk("clr_cnt", g, o_cnt[g], 0);
        idle(1);

        // Reset with two samples in flight
        step(1'b1, 8'h55, 1'b1, TAPS_B, 1'b0);
        step(1'b1, 8'h33, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                chk("rst_mid_valid", g, o_valid[g], 0);
                chk("rst_mid_y",     g, o_y[g],     0);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, TAPS_A, 1'b0);
        idle(2);
        step(1'b1, 8'h20, 1'b0, '0, 1'b0);
        zeros(4);
        idle(3);

        // Small-value rounding case on the 1-tap NBFout=4 instance
        step(1'b1, 8'h01, 1'b1, TAPS_S, 1'b0);
        zeros(3);
        idle(3);

        // Randomised traffic with gaps, loads and phase changes
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0)
                for (int g = 0; g < NI; g++)
                    i_phase[g] = 2'($urandom_range(0, (1 << pw_of(g)) - 1));
            step(($urandom % 10) < 7, 8'($urandom), ($urandom % 20) == 0,
                 CW'($urandom), 1'b0);
        end
        idle(6);

        for (int g = 0; g < NI; g++) chk("drain", g, expq[g].size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
